f_writeback_unit: RTL

Floating-point writeback and FCSR stage sitting directly upstream of the FP register file's write port. It arbitrates between FPU arithmetic results (valid/ready handshake) and FP load data (FLW, never stalled). It registers the winner onto the register file write port and accumulates sticky exception flags into fflags. It also owns the frm/fflags/fcsr CSRs and a per-register busy scoreboard used by issue logic.

---
 rtl/f_writeback_unit_if.sv | 42 ++++
 rtl/f_writeback_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/f_writeback_unit_if.sv
// Bundle between the FP writeback stage and its neighbours: FPU result handshake,
// FLW data, issue scoreboard, register file write port and the FP CSR port.
interface f_writeback_unit_if;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_mask;
  logic        f_wen;
  logic [4:0]  f_rd;
  logic [31:0] f_w_data;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [2:0]  frm_out;
  logic [4:0]  fflags_out;

  modport master (
    output fpu_valid, fpu_rd, fpu_result, fpu_flags,
    output ld_valid, ld_rd, ld_data,
    output issue_valid, issue_rd,
    output csr_wen, csr_addr, csr_wdata,
    input  fpu_ready, busy_mask, f_wen, f_rd, f_w_data,
    input  csr_rdata, frm_out, fflags_out
  );

  modport slave (
    input  fpu_valid, fpu_rd, fpu_result, fpu_flags,
    input  ld_valid, ld_rd, ld_data,
    input  issue_valid, issue_rd,
    input  csr_wen, csr_addr, csr_wdata,
    output fpu_ready, busy_mask, f_wen, f_rd, f_w_data,
    output csr_rdata, frm_out, fflags_out
  );
endinterface

// File: rtl/f_writeback_unit.sv
// FP writeback stage: load-priority arbitration onto the register file write port,
// sticky fflags / frm CSRs, and the per-register FPU busy scoreboard.
module f_writeback_unit (
  input  logic CLK,
  input  logic nRST,
  f_writeback_unit_if.slave wb
);

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  logic        fpu_acc;
  logic        wen_q, wen_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  fflags_q, fflags_d;
  logic [2:0]  frm_q, frm_d;
  logic [31:0] busy_q, busy_d;

  function automatic logic [31:0] csr_read(input logic [11:0] addr,
                                           input logic [2:0] frm,
                                           input logic [4:0] fflags);
    case (addr)
      ADDR_FFLAGS: csr_read = {27'b0, fflags};
      ADDR_FRM:    csr_read = {29'b0, frm};
      ADDR_FCSR:   csr_read = {24'b0, frm, fflags};
      default:     csr_read = 32'b0;
    endcase
  endfunction

  assign wb.fpu_ready = nRST & ~wb.ld_valid;
  assign fpu_acc      = wb.fpu_valid & wb.fpu_ready;

  always_comb begin
    wen_d    = wb.ld_valid | fpu_acc;
    rd_d     = rd_q;
    data_d   = data_q;
    fflags_d = fflags_q;
    frm_d    = frm_q;
    busy_d   = busy_q;

    if (wb.ld_valid) begin
      rd_d   = wb.ld_rd;
      data_d = wb.ld_data;
    end else if (fpu_acc) begin
      rd_d   = wb.fpu_rd;
      data_d = wb.fpu_result;
    end

    if (wb.csr_wen) begin
      case (wb.csr_addr)
        ADDR_FFLAGS: fflags_d = wb.csr_wdata[4:0];
        ADDR_FRM:    frm_d    = wb.csr_wdata[2:0];
        ADDR_FCSR: begin
          frm_d    = wb.csr_wdata[7:5];
          fflags_d = wb.csr_wdata[4:0];
        end
        default: ;
      endcase
    end
    // OR after the CSR write so an accepting FPU op never loses its flags
    if (fpu_acc) fflags_d = fflags_d | wb.fpu_flags;

    // Clear first so a same-cycle issue to the same register stays busy
    if (fpu_acc)        busy_d[wb.fpu_rd]   = 1'b0;
    if (wb.issue_valid) busy_d[wb.issue_rd] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wen_q    <= 1'b0;
      rd_q     <= 5'b0;
      data_q   <= 32'b0;
      fflags_q <= 5'b0;
      frm_q    <= 3'b0;
      busy_q   <= 32'b0;
    end else begin
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
      busy_q   <= busy_d;
    end
  end

  assign wb.f_wen      = wen_q;
  assign wb.f_rd       = rd_q;
  assign wb.f_w_data   = data_q;
  assign wb.fflags_out = fflags_q;
  assign wb.frm_out    = frm_q;
  assign wb.busy_mask  = busy_q;
  assign wb.csr_rdata  = csr_read(wb.csr_addr, frm_q, fflags_q);

endmodule
